// File: rtl/seq_alu.sv
// Registered ALU: single-cycle add/sub/logic/SLT, iterative unsigned multiply and divide.
// Optional V/C flag outputs are enabled by defining SEQ_ALU_FLAGS_EN.
module seq_alu #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             Z
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic             V,
  output logic             C
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_res;
  logic [WIDTH-1:0]     w_hi;
  logic [WIDTH-1:0]     w_lo;
  logic [WIDTH-1:0]     w_hi_n;
  logic [WIDTH-1:0]     w_lo_n;
  logic [WIDTH-1:0]     w_iter_res;
  logic [WIDTH:0]       w_mac;
  logic [WIDTH:0]       w_trial;
  logic                 w_mul_div;
  logic                 w_last;

  assign ready     = (r_state != BUSY);
  assign w_mul_div = (op[3:2] == 2'b11);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_addend = op[0] ? ~B : B;
    w_sum    = A + w_addend + WIDTH'(op[0]);
    w_res    = '0;
    unique case (op[3:2])
      2'b00: w_res = w_sum;
      2'b01: begin
        unique case (op[1:0])
          2'b00: w_res = A & B;
          2'b01: w_res = A | B;
          2'b10: w_res = A ^ B;
          default: w_res = ~(A | B);
        endcase
      end
      2'b10: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: w_res = '0;
    endcase
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic [WIDTH:0] w_full;
  logic           w_v;
  logic           w_c;

  always_comb begin
    w_full = {1'b0, A} + {1'b0, w_addend} + {{WIDTH{1'b0}}, op[0]};
    w_v    = 1'b0;
    w_c    = 1'b0;
    if (op[3:2] == 2'b00) begin
      w_c = w_full[WIDTH];
      w_v = (A[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
    end
  end
`endif

  // r_acc upper half is the partial product / remainder, lower half the
  // shifting multiplier / dividend-becoming-quotient.
  always_comb begin
    w_hi    = r_acc[2*WIDTH-1:WIDTH];
    w_lo    = r_acc[WIDTH-1:0];
    w_mac   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
    w_trial = {w_hi, w_lo[WIDTH-1]} - {1'b0, r_opnd};
    if (!r_op[1]) begin
      w_hi_n = w_mac[WIDTH:1];
      w_lo_n = {w_mac[0], w_lo[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      w_hi_n = w_trial[WIDTH-1:0];
      w_lo_n = {w_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_n = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
      w_lo_n = {w_lo[WIDTH-2:0], 1'b0};
    end
    w_iter_res = r_op[0] ? w_hi_n : w_lo_n;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      done    <= 1'b0;
      Y       <= '0;
      Z       <= 1'b1;
`ifdef SEQ_ALU_FLAGS_EN
      V       <= 1'b0;
      C       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (r_state)
        BUSY: begin
          r_acc <= {w_hi_n, w_lo_n};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= DONE;
            done    <= 1'b1;
            Y       <= w_iter_res;
            Z       <= (w_iter_res == '0);
`ifdef SEQ_ALU_FLAGS_EN
            V       <= 1'b0;
            C       <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          if (start) begin
            if (w_mul_div) begin
              r_state <= BUSY;
              r_cnt   <= '0;
              r_op    <= op[1:0];
              r_opnd  <= op[1] ? B : A;
              r_acc   <= {{WIDTH{1'b0}}, (op[1] ? A : B)};
            end else begin
              r_state <= DONE;
              done    <= 1'b1;
              Y       <= w_res;
              Z       <= (w_res == '0);
`ifdef SEQ_ALU_FLAGS_EN
              V       <= w_v;
              C       <= w_c;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: behavioural reference model checked every cycle plus directed literal vectors.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        done;
  logic [31:0] Y;
  logic        Z;

  logic        s8;
  logic [3:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        rdy8;
  logic        dn8;
  logic [7:0]  y8;
  logic        z8;

`ifdef SEQ_ALU_FLAGS_EN
  logic V, C, v8, c8;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  seq_alu #(.WIDTH(32)) u_dut (
    .clk(clk), .reset_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .ready(ready), .done(done), .Y(Y), .Z(Z)
`ifdef SEQ_ALU_FLAGS_EN
    , .V(V), .C(C)
`endif
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(rst_n), .start(s8), .op(op8), .A(a8), .B(b8),
    .ready(rdy8), .done(dn8), .Y(y8), .Z(z8)
`ifdef SEQ_ALU_FLAGS_EN
    , .V(v8), .C(c8)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    casez (o)
      4'b00?0: return a + b;
      4'b00?1: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~(a | b);
      4'b10??: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return p[31:0];
      4'b1101: return p[63:32];
      4'b1110: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Returns {V, C}.
  function automatic logic [1:0] ref_vc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sr;
    logic [63:0] ur;
    logic ov;
    if (o[3:2] != 2'b00) return 2'b00;
    if (!o[0]) begin
      sr = longint'($signed(a)) + longint'($signed(b));
      ur = {32'b0, a} + {32'b0, b};
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {ov, ur[32]};
    end
    sr = longint'($signed(a)) - longint'($signed(b));
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ov, (a >= b)};
  endfunction

  // Model: remaining-cycles countdown for mul/div; results appear when it expires.
  int          m_cnt;
  logic        m_done;
  logic        m_live = 1'b0;
  logic [31:0] m_y;
  logic [31:0] m_pend;
  logic [1:0]  m_vc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_y    <= '0;
      m_vc   <= 2'b00;
      m_live <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_y  <= m_pend;
        m_vc <= 2'b00;
      end
    end else begin
      m_done <= start;
      if (start) begin
        if (op[3:2] == 2'b11) begin
          m_pend <= ref32(op, A, B);
          m_cnt  <= 32;
          m_done <= 1'b0;
        end else begin
          m_y  <= ref32(op, A, B);
          m_vc <= ref_vc(op, A, B);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("ready", ready, m_cnt == 0);
      chk("done", done, m_done);
      chk("Y", Y, m_y);
      chk("Z", Z, m_y == 0);
`ifdef SEQ_ALU_FLAGS_EN
      chk("V", V, m_vc[1]);
      chk("C", C, m_vc[0]);
`endif
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 1;
    nbusy = ready ? 0 : 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!ready) nbusy++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t vt[$] = '{
    '{4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
    '{4'b0101, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34},
    '{4'b0110, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34},
    '{4'b0111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB},
    '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00E1_1134},
    '{4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hE0FF_1334},
    '{4'b1001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0000_0001},
    '{4'b1011, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000}
  };

  vec_t vm[$] = '{
    '{4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
    '{4'b1110, 32'd100,       32'd7,         32'd14},
    '{4'b1111, 32'd100,       32'd7,         32'd2},
    '{4'b1110, 32'd5,         32'd0,         32'hFFFF_FFFF},
    '{4'b1111, 32'd9,         32'd0,         32'd9}
  };

  initial begin
    int cyc, nbusy, ndone;
    clk   = 1'b0;
    rst_n = 1'b0;
    start = 1'b0; op = '0; A = '0; B = '0;
    s8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_Y", Y, 32'd0);
    chk("rst_Z", Z, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst8_Y", y8, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'b0000, 32'h7FFF_FFFF, 32'd1);
    chk("add_done", done, 1'b1);
    chk("add_Y", Y, 32'h8000_0000);
    chk("add_Z", Z, 1'b0);
`ifdef SEQ_ALU_FLAGS_EN
    chk("add_V", V, 1'b1);
    chk("add_C", C, 1'b0);
`endif
    issue(4'b0001, 32'd5, 32'd5);
    chk("sub_done", done, 1'b1);
    chk("sub_Y", Y, 32'd0);
    chk("sub_Z", Z, 1'b1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd0);
    chk("slt_b2b_done", done, 1'b1);
    chk("slt_Y", Y, 32'd1);
    @(negedge clk);
    chk("idle_after_done", done, 1'b0);

    foreach (vt[i]) begin
      issue(vt[i].o, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_Y", i), Y, vt[i].y);
    end
    @(negedge clk);

    foreach (vm[i]) begin
      issue(vm[i].o, vm[i].a, vm[i].b);
      wait_done(cyc, nbusy);
      chk($sformatf("md%0d_lat", i), cyc, 33);
      chk($sformatf("md%0d_busy", i), nbusy, 32);
      chk($sformatf("md%0d_Y", i), Y, vm[i].y);
    end
    @(negedge clk);

    issue(4'b1100, 32'd3, 32'd5);
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        start = 1'b1; op = 4'b0000; A = 32'd1; B = 32'd1;
      end else begin
        start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("ign_done_seen", done, 1'b1);
    chk("ign_lat", cyc, 33);
    chk("ign_Y", Y, 32'd15);
    @(negedge clk);
    chk("ign_single_done", done, 1'b0);

    issue(4'b1110, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_Y", Y, 32'd0);
    chk("abort_Z", Z, 1'b1);
    chk("abort_done", done, 1'b0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    s8 = 1'b1; op8 = 4'b1100; a8 = 8'd15; b8 = 8'd17;
    @(negedge clk);
    s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    cyc = 1;
    while (!dn8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("w8_done_seen", dn8, 1'b1);
    chk("w8_lat", cyc, 9);
    chk("w8_Y", y8, 8'hFF);
    chk("w8_Z", z8, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor of the combinational 32-bit ALU.
- Keeps the 4-bit opcode map for single-cycle ops (add/sub, logic, SLT).
- Uses the spare op[3:2]=11 space for iterative unsigned multiply and divide.
- Sits between the register-file read stage and writeback. Uses a start/ready/done handshake so the controller can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4).
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only when ready=1.
- op  in  4  operation code, captured with start.
- A  in  WIDTH  operand A, captured with start.
- B  in  WIDTH  operand B, captured with start.
- ready  out  1  block can accept start this cycle.
- done  out  1  one-cycle pulse: Y/Z valid for the new result.
- Y  out  WIDTH  registered result; holds until the next result.
- Z  out  1  registered, =1 iff Y==0.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, Y=0, Z=1, done=0, counter=0, internal operand/accumulator regs=0. Takes priority over everything, including mid-BUSY; an aborted op produces no done.
- Opcode map:
  - 00x0 ADD; 00x1 SUB (op[1] ignored for arithmetic, i.e. op[0]=0 add, op[0]=1 sub).
  - 0100 AND; 0101 OR; 0110 XOR; 0111 NOR.
  - 10xx SLT, signed: Y = {WIDTH-1 zeros, A<B}.
  - 1100 MULLO, low WIDTH bits of A*B, unsigned.
  - 1101 MULHI, high WIDTH bits of A*B, unsigned.
  - 1110 DIVU, quotient; 1111 REMU, remainder.
- Arithmetic is modulo 2^WIDTH; carry-out is discarded.
- States: IDLE, BUSY, DONE. ready = (state != BUSY).
- IDLE/DONE with start=1 and op[3:2]!=11: result computed combinationally and registered at that edge. Next state DONE, so done=1 the following cycle. Latency is 1.
- IDLE/DONE with start=1 and op[3:2]=11: A, B and op are latched, counter=0, next state BUSY.
- BUSY: one iteration per edge. Multiply is shift-add over a 2*WIDTH product register. Divide is restoring, one quotient bit per edge.
  - At the edge where counter==WIDTH-1: Y and Z are loaded with the selected half (quotient or remainder), next state DONE.
  - done rises exactly WIDTH+1 cycles after the start edge.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted (back-to-back, no bubble).
  - Otherwise next state is IDLE.
- start while BUSY is ignored; it is not queued.
- Divide by zero (B==0): quotient = all ones, remainder = A. Still takes the full WIDTH+1 latency.
- A, B and op changing after the start edge have no effect on an in-flight op.
- Y and Z are stable outside done cycles; they change only when a result is loaded or on reset.

Optional Feature:
- Macro SEQ_ALU_FLAGS_EN.
- When defined: adds outputs V (1 bit, signed overflow of ADD/SUB) and C (1 bit, carry-out of ADD, not-borrow of SUB).
  - Both are registered with Y and reset to 0.
  - Both are cleared to 0 for every non-arithmetic op, including MUL/DIV.
- When undefined: V and C ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD, A=32'h7FFF_FFFF, B=1 -> next cycle done=1, Y=32'h8000_0000, Z=0. With flags: V=1, C=0.
- SUB, A=5, B=5 -> done after 1 cycle, Y=0, Z=1. Then back-to-back SLT, A=-1, B=0 in the done cycle -> next cycle done=1, Y=1.
- MULHI, A=B=32'hFFFF_FFFF -> ready=0 for 32 cycles, done at cycle 33, Y=32'hFFFF_FFFE. MULLO with the same operands -> Y=1.
- DIVU, A=100, B=7 -> Y=14 at done. REMU with the same operands -> Y=2. DIVU with B=0 -> Y=32'hFFFF_FFFF. REMU, A=9, B=0 -> Y=9.
- start pulsed while BUSY with a different op -> ignored, original result returned, exactly one done.
- reset_n=0 at BUSY cycle 10 -> next cycle ready=1, Y=0, Z=1, no done. WIDTH=8 instance: MULLO 8'd15*8'd17 -> Y=8'hFF at cycle 9.
